// File: rtl/run_length_detector_if.sv
// Bus bundle for run_length_detector: sample controls in, detect levels/pulses out.
// HIT_CNT/CNT_CLR exist only when RUN_DET_COUNT_EN is defined.
interface run_length_detector_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 4
);
    logic                EN;
    logic [N_CH-1:0]     I;
    logic [CNT_W-1:0]    THRESH;
    logic [N_CH-1:0]     Q;
    logic [N_CH-1:0]     Q_RISE;
`ifdef RUN_DET_COUNT_EN
    logic [N_CH*8-1:0]   HIT_CNT;
    logic                CNT_CLR;

    modport master (output EN, I, THRESH, CNT_CLR, input Q, Q_RISE, HIT_CNT);
    modport slave  (input EN, I, THRESH, CNT_CLR, output Q, Q_RISE, HIT_CNT);
`else
    modport master (output EN, I, THRESH, input Q, Q_RISE);
    modport slave  (input EN, I, THRESH, output Q, Q_RISE);
`endif
endinterface

// File: rtl/run_length_detector.sv
// Multi-channel run-of-ones detector with shared runtime threshold.
// Optional per-channel hit counters when RUN_DET_COUNT_EN is defined.
//
// state    | meaning
// IDLE     | no run in progress, cnt = 0
// COUNTING | run in progress, cnt below threshold
// DETECTED | run length reached threshold, Q held high until a 0
module run_length_detector #(
    parameter int N_CH     = 4,
    parameter int CNT_W    = 4,
    parameter int GAP_HOLD = 0
) (
    input  logic CLK,
    input  logic RST,
    run_length_detector_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        DETECTED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state     [N_CH];
    state_t           state_nxt [N_CH];
    logic [CNT_W-1:0] cnt       [N_CH];
    logic [CNT_W-1:0] cnt_nxt   [N_CH];
    logic [CNT_W-1:0] cnt_inc   [N_CH];
    logic [N_CH-1:0]  q_r, q_nxt;
    logic [N_CH-1:0]  rise_r, rise_nxt;
    logic [CNT_W-1:0] thresh_eff;

    // A threshold of 0 behaves like 1 so a single 1 still qualifies.
    assign thresh_eff = (bus.THRESH == '0) ? CNT_ONE : bus.THRESH;

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            cnt_inc[k] = (cnt[k] == CNT_MAX) ? cnt[k] : cnt[k] + CNT_ONE;
        end
    end

    always_comb begin
        q_nxt    = '0;
        rise_nxt = '0;
        for (int k = 0; k < N_CH; k++) begin
            state_nxt[k] = state[k];
            cnt_nxt[k]   = cnt[k];
            if (bus.EN) begin
                case (state[k])
                    IDLE: begin
                        if (bus.I[k]) begin
                            cnt_nxt[k]   = CNT_ONE;
                            state_nxt[k] = (thresh_eff == CNT_ONE) ? DETECTED : COUNTING;
                        end
                    end
                    COUNTING: begin
                        if (bus.I[k]) begin
                            cnt_nxt[k] = cnt_inc[k];
                            if (cnt_inc[k] >= thresh_eff) begin
                                state_nxt[k] = DETECTED;
                            end
                        end else if (GAP_HOLD == 0) begin
                            cnt_nxt[k]   = '0;
                            state_nxt[k] = IDLE;
                        end
                    end
                    DETECTED: begin
                        if (bus.I[k]) begin
                            cnt_nxt[k] = cnt_inc[k];
                        end else begin
                            cnt_nxt[k]   = '0;
                            state_nxt[k] = IDLE;
                        end
                    end
                    default: begin
                        cnt_nxt[k]   = '0;
                        state_nxt[k] = IDLE;
                    end
                endcase
            end
            q_nxt[k]    = (state_nxt[k] == DETECTED);
            rise_nxt[k] = bus.EN & q_nxt[k] & ~q_r[k];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < N_CH; k++) begin
                state[k] <= IDLE;
                cnt[k]   <= '0;
            end
            q_r    <= '0;
            rise_r <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                state[k] <= state_nxt[k];
                cnt[k]   <= cnt_nxt[k];
            end
            q_r    <= q_nxt;
            rise_r <= rise_nxt;
        end
    end

    assign bus.Q      = q_r;
    assign bus.Q_RISE = rise_r;

`ifdef RUN_DET_COUNT_EN
    logic [7:0] hit [N_CH];

    // Clear is independent of EN and wins over a coincident increment.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < N_CH; k++) hit[k] <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (bus.CNT_CLR) begin
                    hit[k] <= '0;
                end else if (rise_r[k] && hit[k] != 8'hFF) begin
                    hit[k] <= hit[k] + 8'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_hit
        assign bus.HIT_CNT[8*g +: 8] = hit[g];
    end
`endif
endmodule

// File: tb/tb_run_length_detector.sv
// Bench for run_length_detector: GAP_HOLD=0 and GAP_HOLD=1 instances share stimulus;
// a vector table plus hand sequences feed a scoreboard queue of expected outputs.
module tb_run_length_detector;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    run_length_detector_if #(.N_CH(4), .CNT_W(4)) if0 ();
    run_length_detector_if #(.N_CH(4), .CNT_W(4)) if1 ();

    run_length_detector #(.N_CH(4), .CNT_W(4), .GAP_HOLD(0)) dut0 (
        .CLK(CLK), .RST(RST), .bus(if0)
    );
    run_length_detector #(.N_CH(4), .CNT_W(4), .GAP_HOLD(1)) dut1 (
        .CLK(CLK), .RST(RST), .bus(if1)
    );

    typedef struct {
        string      name;
        logic       en;
        logic [3:0] i;
        logic [3:0] th;
        logic [3:0] q0, r0, q1, r1;
    } vec_t;

    typedef struct {
        string      name;
        logic [3:0] q0, r0, q1, r1;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check4(input string nm, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", nm, act, req);
        end
    endtask

    task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic drive(input logic en, input logic [3:0] i, input logic [3:0] th);
        if0.EN = en; if0.I = i; if0.THRESH = th;
        if1.EN = en; if1.I = i; if1.THRESH = th;
    endtask

    task automatic step(input string nm, input logic en, input logic [3:0] i, input logic [3:0] th,
                        input logic [3:0] q0, input logic [3:0] r0,
                        input logic [3:0] q1, input logic [3:0] r1);
        exp_t e;
        drive(en, i, th);
        e.name = nm; e.q0 = q0; e.r0 = r0; e.q1 = q1; e.r1 = r1;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s scoreboard empty", nm);
        end else begin
            e = sb.pop_front();
            check4({e.name, " Q gh0"},      if0.Q,      e.q0);
            check4({e.name, " Q_RISE gh0"}, if0.Q_RISE, e.r0);
            check4({e.name, " Q gh1"},      if1.Q,      e.q1);
            check4({e.name, " Q_RISE gh1"}, if1.Q_RISE, e.r1);
        end
    endtask

    task automatic add(input string nm, input logic [3:0] i, input logic [3:0] th,
                       input logic [3:0] q0, input logic [3:0] r0,
                       input logic [3:0] q1, input logic [3:0] r1);
        vec_t v;
        v.name = nm; v.en = 1'b1; v.i = i; v.th = th;
        v.q0 = q0; v.r0 = r0; v.q1 = q1; v.r1 = r1;
        tbl.push_back(v);
    endtask

    task automatic pulse_reset();
        #2;
        RST = 1'b1;
        #1;
        check4("async reset Q gh0", if0.Q, 4'b0000);
        check4("async reset Q gh1", if1.Q, 4'b0000);
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef RUN_DET_COUNT_EN
        if0.CNT_CLR = 1'b0;
        if1.CNT_CLR = 1'b0;
`endif
        drive(1'b1, 4'b0000, 4'd3);

        // thresh=3, ch0 1,1,1,1,0 with ch2 offset by one
        add("A1", 4'b0001, 4'd3, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add("A2", 4'b0101, 4'd3, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add("A3", 4'b0101, 4'd3, 4'b0001, 4'b0001, 4'b0001, 4'b0001);
        add("A4", 4'b0101, 4'd3, 4'b0101, 4'b0100, 4'b0101, 4'b0100);
        add("A5", 4'b0100, 4'd3, 4'b0100, 4'b0000, 4'b0100, 4'b0000);
        // 1,1,0,1,1,0: gap clears run for gh0, holds it for gh1
        add("B1", 4'b0001, 4'd3, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add("B2", 4'b0001, 4'd3, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add("B3", 4'b0000, 4'd3, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add("B4", 4'b0001, 4'd3, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
        add("B5", 4'b0001, 4'd3, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        add("B6", 4'b0000, 4'd3, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // lower threshold mid-count, then raise it while detected
        add("L1", 4'b0001, 4'd5, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add("L2", 4'b0001, 4'd5, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add("L3", 4'b0001, 4'd5, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add("L4", 4'b0001, 4'd2, 4'b0001, 4'b0001, 4'b0001, 4'b0001);
        add("L5", 4'b0001, 4'd15, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
        add("L6", 4'b0000, 4'd15, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // thresh 0 and 1 both detect on the first 1
        add("C1", 4'b1000, 4'd0, 4'b1000, 4'b1000, 4'b1000, 4'b1000);
        add("C2", 4'b0000, 4'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add("C3", 4'b0010, 4'd1, 4'b0010, 4'b0010, 4'b0010, 4'b0010);
        add("C4", 4'b0000, 4'd1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // reset state
        @(posedge CLK);
        #1;
        check4("in reset Q gh0", if0.Q, 4'b0000);
        check4("in reset Q_RISE gh0", if0.Q_RISE, 4'b0000);
        check4("in reset Q gh1", if1.Q, 4'b0000);
        RST = 1'b0;
        step("post-reset idle", 1'b1, 4'b0000, 4'd3, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
`ifdef RUN_DET_COUNT_EN
        check8("reset HIT_CNT ch0", if0.HIT_CNT[7:0], 8'd0);
        check8("reset HIT_CNT ch1", if0.HIT_CNT[15:8], 8'd0);
`endif

        for (int v = 0; v < tbl.size(); v++) begin
            step(tbl[v].name, tbl[v].en, tbl[v].i, tbl[v].th,
                 tbl[v].q0, tbl[v].r0, tbl[v].q1, tbl[v].r1);
        end

        // thresh=15, 20 ones: rise on 15th edge, hold afterwards
        for (int n = 1; n <= 20; n++) begin
            step($sformatf("run15 n=%0d", n), 1'b1, 4'b0001, 4'd15,
                 (n >= 15) ? 4'b0001 : 4'b0000, (n == 15) ? 4'b0001 : 4'b0000,
                 (n >= 15) ? 4'b0001 : 4'b0000, (n == 15) ? 4'b0001 : 4'b0000);
        end
        step("run15 end", 1'b1, 4'b0000, 4'd15, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // run continues across an EN gap; inputs ignored while disabled
        step("en gap 1", 1'b1, 4'b0001, 4'd3, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("en gap 2", 1'b1, 4'b0001, 4'd3, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        for (int n = 0; n < 4; n++) begin
            step($sformatf("en off %0d", n), 1'b0, 4'b1110, 4'd1,
                 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        end
        step("en resume", 1'b1, 4'b0001, 4'd3, 4'b0001, 4'b0001, 4'b0001, 4'b0001);
        step("en off hold 1", 1'b0, 4'b0000, 4'd3, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
        step("en off hold 2", 1'b0, 4'b0000, 4'd3, 4'b0001, 4'b0000, 4'b0001, 4'b0000);

        // async reset mid-run, then the run must restart from zero
        drive(1'b1, 4'b0001, 4'd3);
        pulse_reset();
        step("restart 1", 1'b1, 4'b0001, 4'd3, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("restart 2", 1'b1, 4'b0001, 4'd3, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("restart 3", 1'b1, 4'b0001, 4'd3, 4'b0001, 4'b0001, 4'b0001, 4'b0001);
        step("restart 4", 1'b1, 4'b0000, 4'd3, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

`ifdef RUN_DET_COUNT_EN
        pulse_reset();
        for (int n = 1; n <= 300; n++) begin
            step("hit rise", 1'b1, 4'b0010, 4'd1, 4'b0010, 4'b0010, 4'b0010, 4'b0010);
            step("hit fall", 1'b1, 4'b0000, 4'd1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
            if (n == 5) check8("HIT_CNT ch1 after 5", if0.HIT_CNT[15:8], 8'd5);
        end
        check8("HIT_CNT ch1 saturated", if0.HIT_CNT[15:8], 8'd255);
        check8("HIT_CNT ch0 untouched", if0.HIT_CNT[7:0], 8'd0);
        step("clr rise", 1'b1, 4'b0010, 4'd1, 4'b0010, 4'b0010, 4'b0010, 4'b0010);
        if0.CNT_CLR = 1'b1;
        if1.CNT_CLR = 1'b1;
        step("clr edge", 1'b1, 4'b0000, 4'd1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        if0.CNT_CLR = 1'b0;
        if1.CNT_CLR = 1'b0;
        check8("HIT_CNT ch1 clear beats inc", if0.HIT_CNT[15:8], 8'd0);
        check8("HIT_CNT ch1 clear gh1", if1.HIT_CNT[15:8], 8'd0);
        step("post clr rise", 1'b1, 4'b0010, 4'd1, 4'b0010, 4'b0010, 4'b0010, 4'b0010);
        step("post clr fall", 1'b1, 4'b0000, 4'd1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        check8("HIT_CNT ch1 recount", if0.HIT_CNT[15:8], 8'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
